// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter fed by the FIFO-drain stage; uart_busy gates the next FIFO read.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) before the stop bit.
`timescale 1ns/1ps
module uart_tx_serializer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       uart_busy,
  output logic       tx,
  output logic       tx_done,
  output logic [2:0] state_dbg
);

  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // Handshake: a byte is taken on any posedge where state is IDLE, data_valid is
  // high and the block is armed; uart_busy is the only back-pressure to the drain stage.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             armed_q;
  logic             tx_d, busy_d, done_d;
  logic             bit_end, accept;

  assign bit_end   = (state_q != S_IDLE) && (cnt_q == CNT_MAX);
  // armed_q blocks acceptance on the first edge after reset release.
  assign accept    = (state_q == S_IDLE) && data_valid && armed_q;
  assign state_dbg = state_q;

`ifdef UART_TX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      par_q <= 1'b0;
    else if (accept) par_q <= (^data) ^ PARITY_ODD;
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // State register plus datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b0;
      tx        <= 1'b1;
      uart_busy <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= 1'b1;
      tx        <= tx_d;
      uart_busy <= busy_d;
      tx_done   <= done_d;
      if (state_q == S_IDLE || bit_end) cnt_q <= '0;
      else                              cnt_q <= cnt_q + 1'b1;
      if (state_q == S_IDLE)                bit_idx_q <= '0;
      else if (state_q == S_DATA && bit_end) bit_idx_q <= bit_idx_q + 1'b1;
      if (accept)                            shift_q <= data;
      else if (state_q == S_DATA && bit_end) shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept)  state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
                end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP:   if (bit_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: computes the value each registered output takes at the next edge.
  always_comb begin
    tx_d   = tx;
    busy_d = uart_busy;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = ~accept;
        busy_d = accept;
      end
      S_START: if (bit_end) tx_d = shift_q[0];
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d = par_q;
`else
            tx_d = 1'b1;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) tx_d = 1'b1;
`endif
      S_STOP: begin
        if (bit_end) begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

endmodule
